// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding, arbitration modes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between the CPU and debug requesters.
// Latency: combinational.
// Backpressure: none; the caller only consumes the result while idle.
// Ports: cpu_req/dbg_req in, last_owner in (port granted most recently),
//        any_req out (either request high), winner out (port to grant).
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR
) (
    input  logic   cpu_req,
    input  logic   dbg_req,
    input  owner_t last_owner,
    output logic   any_req,
    output owner_t winner
);

    always_comb begin
        any_req = cpu_req | dbg_req;
        winner  = OWN_CPU;
        if (cpu_req && dbg_req) begin
            if (ARB_MODE == ARB_FIXED) begin
                winner = OWN_CPU;
            end else begin
                // Round-robin: the port that was not served last wins the tie.
                winner = (last_owner == OWN_CPU) ? OWN_DBG : OWN_CPU;
            end
        end else if (dbg_req) begin
            winner = OWN_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU (port 0) and a debug/loader (port 1).
// Latency: gnt 1 cycle after req is sampled; read rvalid 3 cycles after; write done in 2.
// Backpressure: req is sampled only in IDLE; a requester holds req/we/addr/wdata until gnt.
// Ports: cpu_*/dbg_* request groups (req, we, addr, wdata in; gnt, rvalid, err out),
//        rdata (shared registered read data), busy, mem_* memory-side strobe/address/data.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic              cpu_err,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic              dbg_err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state;
    owner_t            owner;
    owner_t            last_owner;
    logic              lat_we;
    logic              lat_oor;

    logic              any_req;
    owner_t            winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oor;

    dmem_arb_pick #(
        .ARB_MODE(ARB_MODE)
    ) u_pick (
        .cpu_req   (cpu_req),
        .dbg_req   (dbg_req),
        .last_owner(last_owner),
        .any_req   (any_req),
        .winner    (winner)
    );

    assign sel_we    = (winner == OWN_DBG) ? dbg_we    : cpu_we;
    assign sel_addr  = (winner == OWN_DBG) ? dbg_addr  : cpu_addr;
    assign sel_wdata = (winner == OWN_DBG) ? dbg_wdata : cpu_wdata;
    // No wrap-around: anything at or beyond DEPTH is flagged, never folded back.
    assign sel_oor   = (32'(sel_addr) >= 32'(DEPTH));

    // mem_addr/mem_wdata act as the address/data latches and hold between accesses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_DBG;   // so the CPU wins the first tie
            lat_we     <= 1'b0;
            lat_oor    <= 1'b0;
            cpu_gnt    <= 1'b0;
            dbg_gnt    <= 1'b0;
            cpu_err    <= 1'b0;
            dbg_err    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            rdata      <= '0;
            busy       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            // Pulse outputs default low every cycle.
            cpu_gnt    <= 1'b0;
            dbg_gnt    <= 1'b0;
            cpu_err    <= 1'b0;
            dbg_err    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= ACCESS;
                        busy       <= 1'b1;
                        owner      <= winner;
                        last_owner <= winner;
                        lat_we     <= sel_we;
                        lat_oor    <= sel_oor;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        cpu_gnt    <= (winner == OWN_CPU);
                        dbg_gnt    <= (winner == OWN_DBG);
                        cpu_err    <= (winner == OWN_CPU) && sel_oor;
                        dbg_err    <= (winner == OWN_DBG) && sel_oor;
                        mem_en     <= !sel_oor;
                        mem_we     <= sel_we && !sel_oor;
                    end
                end
                ACCESS: begin
                    if (lat_we) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    // Memory data from the ACCESS strobe is valid in this cycle.
                    state      <= IDLE;
                    busy       <= 1'b0;
                    rdata      <= lat_oor ? '0 : mem_rdata;
                    cpu_rvalid <= (owner == OWN_CPU);
                    dbg_rvalid <= (owner == OWN_DBG);
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: one round-robin and one fixed-priority instance,
// each with its own behavioural memory; transaction-level reference model in the bench.
// Directed scenarios followed by randomized single/contended accesses.
module tb_dmem_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic reset;

    logic [1:0]         cpu_req, cpu_we, dbg_req, dbg_we;
    logic [1:0][AW-1:0] cpu_addr, dbg_addr;
    logic [1:0][DW-1:0] cpu_wdata, dbg_wdata;
    logic [1:0]         cpu_gnt, cpu_rvalid, cpu_err;
    logic [1:0]         dbg_gnt, dbg_rvalid, dbg_err;
    logic [1:0]         busy, mem_en, mem_we;
    logic [1:0][DW-1:0] rdata, mem_wdata;
    logic [1:0][AW-1:0] mem_addr;
    logic [DW-1:0]      mem_rdata0, mem_rdata1;

    bit [DW-1:0] mem0 [DEPTH];
    bit [DW-1:0] mem1 [DEPTH];

    // Reference model state
    bit [DW-1:0] ref_mem [2][DEPTH];
    int          m_last  [2];
    logic [DW-1:0] m_rdata [2];
    bit          q_we    [2][2];
    logic [AW-1:0] q_addr [2][2];
    logic [DW-1:0] q_wdata [2][2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .ARB_MODE(0)) u_rr (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
        .cpu_gnt(cpu_gnt[0]), .cpu_rvalid(cpu_rvalid[0]), .cpu_err(cpu_err[0]),
        .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]), .dbg_wdata(dbg_wdata[0]),
        .dbg_gnt(dbg_gnt[0]), .dbg_rvalid(dbg_rvalid[0]), .dbg_err(dbg_err[0]),
        .rdata(rdata[0]), .busy(busy[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata0)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .ARB_MODE(1)) u_fp (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
        .cpu_gnt(cpu_gnt[1]), .cpu_rvalid(cpu_rvalid[1]), .cpu_err(cpu_err[1]),
        .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]), .dbg_wdata(dbg_wdata[1]),
        .dbg_gnt(dbg_gnt[1]), .dbg_rvalid(dbg_rvalid[1]), .dbg_err(dbg_err[1]),
        .rdata(rdata[1]), .busy(busy[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata1)
    );

    // Single-port memories with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en[0]) begin
            if (mem_we[0]) mem0[mem_addr[0][7:0]] <= mem_wdata[0];
            else           mem_rdata0 <= mem0[mem_addr[0][7:0]];
        end
    end

    always @(posedge clk) begin
        if (mem_en[1]) begin
            if (mem_we[1]) mem1[mem_addr[1][7:0]] <= mem_wdata[1];
            else           mem_rdata1 <= mem1[mem_addr[1][7:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic gnt_of(input int d, input int p);
        return (p == 0) ? cpu_gnt[d] : dbg_gnt[d];
    endfunction

    function automatic logic err_of(input int d, input int p);
        return (p == 0) ? cpu_err[d] : dbg_err[d];
    endfunction

    function automatic logic rvalid_of(input int d, input int p);
        return (p == 0) ? cpu_rvalid[d] : dbg_rvalid[d];
    endfunction

    function automatic logic [DW-1:0] mem_word(input int d, input logic [AW-1:0] a);
        return (d == 0) ? mem0[a[7:0]] : mem1[a[7:0]];
    endfunction

    // Arbitration rule: lone requester wins; on a tie the fixed instance favours the
    // CPU and the round-robin instance favours whichever port was not served last.
    function automatic int m_pick(input int d, input bit c, input bit g);
        if (c && g) begin
            if (d == 1) return 0;
            return (m_last[d] == 0) ? 1 : 0;
        end
        return c ? 0 : 1;
    endfunction

    task automatic set_req(input int d, input int p, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] w);
        q_we[d][p]    = we;
        q_addr[d][p]  = a;
        q_wdata[d][p] = w;
        if (p == 0) begin
            cpu_req[d] = 1'b1; cpu_we[d] = we; cpu_addr[d] = a; cpu_wdata[d] = w;
        end else begin
            dbg_req[d] = 1'b1; dbg_we[d] = we; dbg_addr[d] = a; dbg_wdata[d] = w;
        end
    endtask

    task automatic clr_req(input int d, input int p);
        if (p == 0) cpu_req[d] = 1'b0;
        else        dbg_req[d] = 1'b0;
    endtask

    task automatic check_all_zero(input int d, input string tag);
        check_eq({tag, ".ctl"}, {cpu_gnt[d], cpu_rvalid[d], cpu_err[d], dbg_gnt[d],
                                 dbg_rvalid[d], dbg_err[d], busy[d], mem_en[d], mem_we[d]}, 0);
        check_eq({tag, ".rdata"}, rdata[d], 0);
        check_eq({tag, ".maddr"}, {mem_addr[d], mem_wdata[d]}, 0);
    endtask

    // Called in an IDLE cycle (just after a rising edge) with requests already driven;
    // follows one transaction to completion and leaves the DUT about to sample again.
    task automatic expect_txn(input int d, input bit hold);
        int            p;
        bit            we;
        bit            oor;
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        logic [DW-1:0] exp_rd;
        string         t;
        p   = m_pick(d, cpu_req[d], dbg_req[d]);
        we  = q_we[d][p];
        a   = q_addr[d][p];
        w   = q_wdata[d][p];
        oor = (int'(a) >= DEPTH);
        t   = $sformatf("d%0d.p%0d.%s@%0d", d, p, we ? "wr" : "rd", a);

        @(posedge clk); #1;
        check_eq({t, ".gnt"},    gnt_of(d, p), 1'b1);
        check_eq({t, ".ogn"},    gnt_of(d, 1 - p), 1'b0);
        check_eq({t, ".err"},    err_of(d, p), oor);
        check_eq({t, ".oerr"},   err_of(d, 1 - p), 1'b0);
        check_eq({t, ".men"},    mem_en[d], !oor);
        check_eq({t, ".mwe"},    mem_we[d], we && !oor);
        check_eq({t, ".maddr"},  mem_addr[d], a);
        if (we) check_eq({t, ".mwd"}, mem_wdata[d], w);
        check_eq({t, ".busy1"},  busy[d], 1'b1);
        m_last[d] = p;
        if (!hold) clr_req(d, p);

        if (we) begin
            if (!oor) ref_mem[d][a] = w;
            @(posedge clk); #1;
            check_eq({t, ".rv"},    {cpu_rvalid[d], dbg_rvalid[d]}, 2'b00);
            check_eq({t, ".busy0"}, busy[d], 1'b0);
            check_eq({t, ".rhold"}, rdata[d], m_rdata[d]);
            if (!oor) check_eq({t, ".memw"}, mem_word(d, a), w);
        end else begin
            exp_rd = oor ? '0 : ref_mem[d][a];
            @(posedge clk); #1;
            check_eq({t, ".rv_resp"}, {cpu_rvalid[d], dbg_rvalid[d]}, 2'b00);
            check_eq({t, ".busy_r"},  busy[d], 1'b1);
            @(posedge clk); #1;
            check_eq({t, ".rv"},    rvalid_of(d, p), 1'b1);
            check_eq({t, ".orv"},   rvalid_of(d, 1 - p), 1'b0);
            check_eq({t, ".rdata"}, rdata[d], exp_rd);
            check_eq({t, ".busy0"}, busy[d], 1'b0);
            m_rdata[d] = exp_rd;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_last[d]  = 1;
            m_rdata[d] = '0;
        end
    endtask

    initial begin
        cpu_req = '0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = '0; dbg_we = '0; dbg_addr = '0; dbg_wdata = '0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero(0, "rst0");
        check_all_zero(1, "rst1");
        reset = 1'b0;

        // Round-robin contention straight out of reset: CPU, DBG, CPU, DBG.
        set_req(0, 0, 1'b0, 16'd4, '0);
        set_req(0, 1, 1'b0, 16'd5, '0);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("rr.turn%0d", i), m_pick(0, 1'b1, 1'b1), i % 2);
            expect_txn(0, 1'b1);
        end
        clr_req(0, 0);
        clr_req(0, 1);

        // Debug preload then CPU read.
        set_req(0, 1, 1'b1, 16'd16, 32'd20);
        expect_txn(0, 1'b0);
        set_req(0, 1, 1'b1, 16'd32, 32'd22);
        expect_txn(0, 1'b0);
        set_req(0, 0, 1'b0, 16'd32, '0);
        expect_txn(0, 1'b0);
        check_eq("cpu_rd32", m_rdata[0], 32'd22);

        // Out-of-range write and read.
        set_req(0, 0, 1'b1, 16'd300, 32'hDEAD);
        expect_txn(0, 1'b0);
        check_eq("oor.nowrap", mem0[44], ref_mem[0][44]);
        set_req(0, 1, 1'b0, 16'd300, '0);
        expect_txn(0, 1'b0);

        // Fixed priority: CPU keeps winning while it holds req.
        set_req(1, 0, 1'b1, 16'd48, 32'd42);
        set_req(1, 1, 1'b0, 16'd48, '0);
        for (int i = 0; i < 3; i++) expect_txn(1, 1'b1);
        clr_req(1, 0);
        expect_txn(1, 1'b0);
        check_eq("fp.mem48", mem1[48], 32'd42);
        check_eq("fp.dbg_rd", m_rdata[1], 32'd42);

        // Randomized accesses away from the directed addresses.
        for (int i = 0; i < 200; i++) begin
            int d;
            bit c, g;
            d = int'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            g = 1'($urandom_range(0, 1));
            if (!c && !g) c = 1'b1;
            if (c) set_req(d, 0, 1'($urandom_range(0, 1)), 16'($urandom_range(64, 299)), $urandom);
            if (g) set_req(d, 1, 1'($urandom_range(0, 1)), 16'($urandom_range(64, 299)), $urandom);
            expect_txn(d, 1'b0);
            if (cpu_req[d] || dbg_req[d]) expect_txn(d, 1'b0);
        end

        // Reset during RESP drops the read.
        set_req(0, 0, 1'b0, 16'd32, '0);
        @(posedge clk); #1;
        check_eq("mid.gnt", cpu_gnt[0], 1'b1);
        clr_req(0, 0);
        @(posedge clk); #1;
        check_eq("mid.busy", busy[0], 1'b1);
        reset = 1'b1;
        #1;
        check_all_zero(0, "mid.rst0");
        check_all_zero(1, "mid.rst1");
        @(posedge clk); #1;
        check_eq("mid.rv", {cpu_rvalid[0], dbg_rvalid[0]}, 2'b00);
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_eq("post.rv", {cpu_rvalid[0], dbg_rvalid[0]}, 2'b00);
        check_eq("post.rdata", rdata[0], 0);
        set_req(0, 0, 1'b0, 16'd16, '0);
        expect_txn(0, 1'b0);
        check_eq("post.rd16", rdata[0], 32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
